uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receive stage sitting directly downstream of the baud rate generator. It consumes the 16x oversampling tick, synchronises the asynchronous `rx_i` line, detects and validates the start bit, and samples each data, parity and stop bit at its centre. It presents the assembled character plus error flags to the register/FIFO layer through a valid/ready handshake.

## Interface
- `OVS_RATE`, 16: ticks per bit; must match the generator's oversampling factor. Power of two, ≥ 8.
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `ov_tick_i`  in  1  one-cycle oversampling pulse, OVS_RATE per bit period.
- `rx_i`  in  1  asynchronous serial line, idle high.
- `data_bits_i`  in  2  character length: 0→5, 1→6, 2→7, 3→8 bits.
- `parity_en_i`  in  1  parity bit present.
- `parity_odd_i`  in  1  1 = odd parity, 0 = even parity.
- `stop2_i`  in  1  1 = two stop bits.
- `rx_data_o`  out  8  received character, LSB-aligned, unused MSBs zero.
- `rx_valid_o`  out  1  character available.
- `rx_ready_i`  in  1  consumer accepts character when high together with `rx_valid_o`.
- `parity_err_o`  out  1  parity mismatch for the held character.
- `frame_err_o`  out  1  a stop bit sampled low for the held character.
- `overrun_o`  out  1  sticky: one or more characters were lost while `rx_valid_o` was high.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- `rx_i` passes through a 2-flop synchroniser (reset value 1); all logic uses the synchronised value `rx_s`.
- All bit timing advances only on `ov_tick_i`; the 4-bit tick counter resets to 0 on every state entry.
- IDLE: armed once `rx_s` = 1 has been seen. When armed and `rx_s` = 0, latch the config inputs, go to START. Config changes mid-frame are ignored.
- START: on the (OVS_RATE/2)-th tick, sample `rx_s`. If 0, go to DATA. If 1, treat as a glitch: return to IDLE with no output and no flags.
- DATA: on every OVS_RATE-th tick, shift `rx_s` in LSB first. Bit counter 0..N-1. After bit N-1, go to PARITY if enabled, otherwise STOP.
- PARITY: sample after OVS_RATE ticks. Error = (XOR of data bits ^ sampled bit) != `parity_odd`.
- STOP: sample after OVS_RATE ticks. A low sample sets the frame error. With `stop2`, sample a second stop bit after a further OVS_RATE ticks; either low sample gives a frame error.
- Completion happens at the centre of the last stop bit. The FSM returns to IDLE disarmed, so a low line (break) cannot retrigger reception.
- Output register:
  - If `rx_valid_o` = 0, load data and both errors, and set `rx_valid_o`.
  - If `rx_valid_o` = 1, drop the new character and set `overrun_o`.
- Handshake: `rx_valid_o & rx_ready_i` clears `rx_valid_o` and `overrun_o`. Data and errors stay stable while valid is high.
- Completion in the same cycle as acceptance: the new character loads, valid stays 1, and no overrun is flagged.

## Timing
- Reset values:
  - state IDLE, disarmed;
  - `rx_data_o` = 0;
  - `rx_valid_o`, `parity_err_o`, `frame_err_o`, `overrun_o`, `busy_o` = 0.
- Synchroniser latency: 2 clk.
- `rx_valid_o` rises 1 clk after the `ov_tick_i` that samples the final stop bit.
- Frame duration from falling edge to valid: (OVS_RATE/2 + OVS_RATE·(N + P + S)) ticks, plus synchroniser and register latency. Here N = data bits, P = 1 if parity is enabled (else 0), S = number of stop bits.
- `busy_o` rises 1 clk after start detection and falls on return to IDLE.
- Reset asserted mid-frame: immediate return to reset values; the partial character is discarded.

## Structure
- `uart_pkg`: state enum (IDLE, START, DATA, PARITY, STOP), data-length encoding constants, `OVS_RATE` default.
- Sub-module `sync_2ff` (2-flop synchroniser, parameterised reset value); the FSM and datapath stay in `uart_receiver`.

## Test plan
- **8N1, 0x55:**
  - stimulus: `data_bits_i` = 3, parity off, one stop bit;
  - response: `rx_data_o` = 0x55, `rx_valid_o` after 9.5 bit periods, no errors.
- **7O2, 0x3A:**
  - stimulus: even number of ones, so parity bit = 1 is sent;
  - response: 0x3A, `parity_err_o` = 0. Repeat with parity bit 0 → `parity_err_o` = 1.
- **Glitch:**
  - stimulus: `rx_i` low for 4 ticks only;
  - response: no valid, `busy_o` returns 0, next 0xA5 frame received correctly.
- **Break:**
  - stimulus: `rx_i` held low for 3 character times;
  - response: one character 0x00 with `frame_err_o` = 1, no further frames until the line returns high.
- **Overrun:**
  - stimulus: `rx_ready_i` = 0, frames 0x11 then 0x22;
  - response: `rx_data_o` = 0x11, `overrun_o` = 1. Acceptance clears both flags.
- **Reset mid-frame:**
  - stimulus: assert `rst_i` during DATA bit 3;
  - response: all outputs return to reset values, then a subsequent 0xC3 frame is received intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: FSM states, the
// data-length encoding and the latched per-frame configuration.
package uart_pkg;

  localparam int unsigned OVS_RATE_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic [1:0] DBITS_5 = 2'd0;
  localparam logic [1:0] DBITS_6 = 2'd1;
  localparam logic [1:0] DBITS_7 = 2'd2;
  localparam logic [1:0] DBITS_8 = 2'd3;

  typedef struct packed {
    logic [1:0] dbits;
    logic       par_en;
    logic       par_odd;
    logic       stop2;
  } rx_cfg_t;

  // Index of the final data bit for a given length encoding (5..8 bits -> 4..7).
  function automatic logic [2:0] last_bit_idx(input logic [1:0] enc);
    return {1'b0, enc} + 3'd4;
  endfunction

endpackage

// File: rtl/uart_receiver_sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit; 2 clk latency, no flow control.
// RST_VAL presets both stages so an idle-high line reads as idle out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: oversampled start/data/parity/stop sampling; valid 1 clk after the last stop sample.
// Character held until rx_ready_i; frames completing while one is held are dropped and flagged as overrun.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned OVS_RATE = OVS_RATE_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ov_tick_i,
  input  logic       rx_i,
  input  logic [1:0] data_bits_i,
  input  logic       parity_en_i,
  input  logic       parity_odd_i,
  input  logic       stop2_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int unsigned TW = $clog2(OVS_RATE);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVS_RATE / 2 - 1);
  localparam logic [TW-1:0] TICK_FULL = TW'(OVS_RATE - 1);

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  rx_state_e     state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic          armed_q, armed_d;
  rx_cfg_t       cfg_q, cfg_d;
  logic [7:0]    shift_q, shift_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          stop_q, stop_d;
  logic          done;
  logic          ferr_nx;
  logic          bit_tick;

  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          perr_o_q, perr_o_d;
  logic          ferr_o_q, ferr_o_d;
  logic          ovr_q, ovr_d;
  logic          accept;

  assign bit_tick = ov_tick_i && (tick_q == TICK_FULL);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    armed_d = armed_q;
    cfg_d   = cfg_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    stop_d  = stop_q;
    ferr_nx = ferr_q;
    done    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Only a high-to-low transition may start a frame, so a held break is ignored.
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = ST_START;
          armed_d = 1'b0;
          tick_d  = '0;
          bit_d   = '0;
          stop_d  = 1'b0;
          shift_d = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          cfg_d   = '{dbits: data_bits_i, par_en: parity_en_i,
                      par_odd: parity_odd_i, stop2: stop2_i};
        end
      end

      ST_START: begin
        if (ov_tick_i) begin
          if (tick_q == TICK_HALF) begin
            tick_d  = '0;
            state_d = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (ov_tick_i) begin
          tick_d = bit_tick ? '0 : tick_q + 1'b1;
        end
        if (bit_tick) begin
          shift_d[bit_q] = rx_s;
          if (bit_q == last_bit_idx(cfg_q.dbits)) begin
            state_d = cfg_q.par_en ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      ST_PARITY: begin
        if (ov_tick_i) begin
          tick_d = bit_tick ? '0 : tick_q + 1'b1;
        end
        if (bit_tick) begin
          perr_d  = ((^shift_q) ^ rx_s) != cfg_q.par_odd;
          state_d = ST_STOP;
        end
      end

      ST_STOP: begin
        if (ov_tick_i) begin
          tick_d = bit_tick ? '0 : tick_q + 1'b1;
        end
        if (bit_tick) begin
          ferr_nx = ferr_q | ~rx_s;
          ferr_d  = ferr_nx;
          if (cfg_q.stop2 && !stop_q) begin
            stop_d = 1'b1;
          end else begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = valid_q & rx_ready_i;

  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    perr_o_d = perr_o_q;
    ferr_o_d = ferr_o_q;
    ovr_d    = ovr_q;

    if (accept) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    // A slot freed by this cycle's acceptance can take the completing character.
    if (done) begin
      if (!valid_q || accept) begin
        data_d   = shift_q;
        perr_o_d = perr_q;
        ferr_o_d = ferr_nx;
        valid_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      armed_q  <= 1'b0;
      cfg_q    <= '0;
      shift_q  <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      stop_q   <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_o_q <= 1'b0;
      ferr_o_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      armed_q  <= armed_d;
      cfg_q    <= cfg_d;
      shift_q  <= shift_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      stop_q   <= stop_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      perr_o_q <= perr_o_d;
      ferr_o_q <= ferr_o_d;
      ovr_q    <= ovr_d;
    end
  end

  assign rx_data_o    = data_q;
  assign rx_valid_o   = valid_q;
  assign parity_err_o = perr_o_q;
  assign frame_err_o  = ferr_o_q;
  assign overrun_o    = ovr_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed frames push expected characters,
// a negedge monitor pops and compares on every accepted character.
module tb_uart_receiver;

  localparam int OVS    = 16;
  localparam int TDIV   = 4;
  localparam int BITCLK = OVS * TDIV;

  logic       clk, rst, ov_tick, rx;
  logic [1:0] dbits;
  logic       par_en, par_odd, stop2, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, perr, ferr, ovr, busy;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   last_valid_cyc = 0;
  int   frame_t0 = 0;
  int   lat;
  int   n0;

  uart_receiver #(.OVS_RATE(OVS)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ov_tick_i    (ov_tick),
    .rx_i         (rx),
    .data_bits_i  (dbits),
    .parity_en_i  (par_en),
    .parity_odd_i (par_odd),
    .stop2_i      (stop2),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .rx_ready_i   (rx_ready),
    .parity_err_o (perr),
    .frame_err_o  (ferr),
    .overrun_o    (ovr),
    .busy_o       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    ov_tick = 1'b0;
    forever begin
      repeat (TDIV - 1) @(posedge clk);
      #1 ov_tick = 1'b1;
      @(posedge clk);
      #1 ov_tick = 1'b0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      n_out++;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_char actual=%0h required=none", rx_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rx_data", {24'd0, rx_data}, {24'd0, mon_e.d});
        chk("parity_err", {31'd0, perr}, {31'd0, mon_e.pe});
        chk("frame_err", {31'd0, ferr}, {31'd0, mon_e.fe});
        chk("overrun", {31'd0, ovr}, {31'd0, mon_e.ov});
      end
    end
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BITCLK) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BITCLK) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] db, input logic pe, input logic po, input logic s2);
    dbits   = db;
    par_en  = pe;
    par_odd = po;
    stop2   = s2;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                            input logic pbit, input int nstop);
    frame_t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    for (int i = 0; i < nstop; i++) drive_bit(1'b1);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 4 * BITCLK) begin
      @(posedge clk);
      k++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain actual=%0d pending required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b1;
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", {24'd0, rx_data}, 32'h0);
    chk("reset_valid", {31'd0, rx_valid}, 32'h0);
    chk("reset_perr", {31'd0, perr}, 32'h0);
    chk("reset_ferr", {31'd0, ferr}, 32'h0);
    chk("reset_ovr", {31'd0, ovr}, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'h0);
    rst = 1'b0;
    idle_bits(2);

    // 8N1 0x55 with start-to-valid latency of 9.5 bits plus sync/register delay
    exp_q.push_back('{d: 8'h55, pe: 1'b0, fe: 1'b0, ov: 1'b0});
    send_frame(8'h55, 8, 1'b0, 1'b0, 1);
    wait_drain("8n1");
    lat = last_valid_cyc - frame_t0;
    checks++;
    if (lat < 9 * BITCLK + BITCLK / 2 || lat > 9 * BITCLK + BITCLK / 2 + 5) begin
      errors++;
      $display("FAIL latency_8n1 actual=%0d required=%0d..%0d", lat,
               9 * BITCLK + BITCLK / 2, 9 * BITCLK + BITCLK / 2 + 5);
    end
    idle_bits(1);

    // 7O2 0x3A: four ones, so odd parity needs a 1 on the line
    set_cfg(2'd2, 1'b1, 1'b1, 1'b1);
    exp_q.push_back('{d: 8'h3A, pe: 1'b0, fe: 1'b0, ov: 1'b0});
    send_frame(8'h3A, 7, 1'b1, 1'b1, 2);
    wait_drain("7o2_good");
    exp_q.push_back('{d: 8'h3A, pe: 1'b1, fe: 1'b0, ov: 1'b0});
    send_frame(8'h3A, 7, 1'b1, 1'b0, 2);
    wait_drain("7o2_bad");
    idle_bits(1);

    // Glitch: low for 4 ticks only
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    n0 = n_out;
    rx = 1'b0;
    repeat (4 * TDIV) @(posedge clk);
    #1;
    rx = 1'b1;
    chk("glitch_busy_high", {31'd0, busy}, 32'h1);
    idle_bits(1);
    chk("glitch_busy_low", {31'd0, busy}, 32'h0);
    chk("glitch_no_char", n_out - n0, 32'h0);
    exp_q.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0, ov: 1'b0});
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1);
    wait_drain("after_glitch");
    idle_bits(1);

    // Break: line low for three character times
    n0 = n_out;
    exp_q.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1, ov: 1'b0});
    rx = 1'b0;
    repeat (30 * BITCLK) @(posedge clk);
    #1;
    chk("break_char_count", n_out - n0, 32'h1);
    chk("break_busy", {31'd0, busy}, 32'h0);
    wait_drain("break");
    idle_bits(2);
    exp_q.push_back('{d: 8'h5A, pe: 1'b0, fe: 1'b0, ov: 1'b0});
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1);
    wait_drain("after_break");
    idle_bits(1);

    // Overrun: two frames with the consumer stalled
    rx_ready = 1'b0;
    exp_q.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0, ov: 1'b1});
    send_frame(8'h11, 8, 1'b0, 1'b0, 1);
    idle_bits(1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1);
    idle_bits(1);
    chk("ovr_held_data", {24'd0, rx_data}, 32'h11);
    chk("ovr_valid", {31'd0, rx_valid}, 32'h1);
    chk("ovr_flag", {31'd0, ovr}, 32'h1);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr_valid_cleared", {31'd0, rx_valid}, 32'h0);
    chk("ovr_flag_cleared", {31'd0, ovr}, 32'h0);
    wait_drain("overrun");
    idle_bits(1);

    // Reset during data bit 3, then a clean 0xC3
    n0 = n_out;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx = 1'b0;
    repeat (BITCLK / 2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_data", {24'd0, rx_data}, 32'h0);
    chk("rst_mid_valid", {31'd0, rx_valid}, 32'h0);
    chk("rst_mid_perr", {31'd0, perr}, 32'h0);
    chk("rst_mid_ferr", {31'd0, ferr}, 32'h0);
    chk("rst_mid_ovr", {31'd0, ovr}, 32'h0);
    chk("rst_mid_busy", {31'd0, busy}, 32'h0);
    rx  = 1'b1;
    rst = 1'b0;
    idle_bits(2);
    chk("rst_no_partial_char", n_out - n0, 32'h0);
    exp_q.push_back('{d: 8'hC3, pe: 1'b0, fe: 1'b0, ov: 1'b0});
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1);
    wait_drain("after_reset");
    idle_bits(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
